frame_draw_sequencer: RTL and testbench

- Per-frame initiator for the drawing controllers. It drives the start/done level handshake that the background draw controller and the object/sprite draw controller answer.
- On each frame tick it requests one background redraw, optionally with a clear-to-black flag. It then requests one draw per object slot, then reports frame completion.
- Sits between the game-logic top level and the draw controllers. It owns frame pacing and frame-overrun accounting.

---
 rtl/draw_pkg.sv | 14 +
 rtl/frame_draw_sequencer_if.sv | 33 +++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/frame_draw_sequencer.sv | 97 +++++++++
 tb/tb_frame_draw_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Definitions shared by the frame sequencer and the draw controllers it drives.
// The state encoding is exported so bound checkers can decode state_dbg.
package draw_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BG_REQ  = 3'd1;
  localparam logic [2:0] ST_BG_REL  = 3'd2;
  localparam logic [2:0] ST_OBJ_REQ = 3'd3;
  localparam logic [2:0] ST_OBJ_REL = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam int SCREEN_PIXELS = 76800;

endpackage

// File: rtl/frame_draw_sequencer_if.sv
// Start/done links between the frame sequencer (master) and the two drawers (slave).
interface frame_draw_sequencer_if;

  // Four-phase level handshake, per client: master raises start and holds it
  // until it samples done=1, drops start on the next cycle, and never re-raises
  // start to that client until it has sampled done=0. done may linger high
  // after start falls for as long as the drawer needs.
  logic       start_draw_bg;
  logic       clear_screen;
  logic       draw_bg_done;
  logic       start_draw_obj;
  logic [2:0] obj_index;
  logic       draw_obj_done;

  modport master (
    output start_draw_bg,
    output clear_screen,
    output start_draw_obj,
    output obj_index,
    input  draw_bg_done,
    input  draw_obj_done
  );

  modport slave (
    input  start_draw_bg,
    input  clear_screen,
    input  start_draw_obj,
    input  obj_index,
    output draw_bg_done,
    output draw_obj_done
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Free-running frame pacing counter; frame_tick is high for the single cycle
// in which the counter holds TICK_DIV-1.
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic frame_tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign frame_tick = (cnt == LAST);

endmodule

// File: rtl/frame_draw_sequencer.sv
// Per-frame initiator: on each frame tick requests one background draw, then
// one draw per object slot (skipped on clear frames), then pulses frame_done.
module frame_draw_sequencer
  import draw_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int NUM_OBJ  = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  game_over,
  frame_draw_sequencer_if.master draw,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic [7:0]            overrun_count,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] LAST_OBJ = 3'(NUM_OBJ - 1);

  logic       frame_tick;
  logic [2:0] state;
  logic [2:0] state_nx;
  logic       start_bg_q;
  logic       start_obj_q;
  logic       clear_q;
  logic [2:0] obj_idx_q;

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (frame_tick && enable) state_nx = ST_BG_REQ;
      ST_BG_REQ:  if (draw.draw_bg_done)    state_nx = ST_BG_REL;
      ST_BG_REL:  if (!draw.draw_bg_done)   state_nx = clear_q ? ST_DONE : ST_OBJ_REQ;
      ST_OBJ_REQ: if (draw.draw_obj_done)   state_nx = ST_OBJ_REL;
      ST_OBJ_REL: if (!draw.draw_obj_done)  state_nx = (obj_idx_q == LAST_OBJ) ? ST_DONE : ST_OBJ_REQ;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Request and status outputs are decoded from the next state so they are
  // registered yet line up exactly with the state they belong to.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      start_bg_q    <= 1'b0;
      start_obj_q   <= 1'b0;
      clear_q       <= 1'b0;
      obj_idx_q     <= 3'd0;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= 8'd0;
      overrun_count <= 8'd0;
    end else begin
      state       <= state_nx;
      start_bg_q  <= (state_nx == ST_BG_REQ);
      start_obj_q <= (state_nx == ST_OBJ_REQ);
      frame_busy  <= (state_nx != ST_IDLE);
      frame_done  <= (state_nx == ST_DONE);

      if (state == ST_IDLE && state_nx == ST_BG_REQ) begin
        clear_q   <= game_over;
        obj_idx_q <= 3'd0;
      end
      if (state == ST_OBJ_REL && state_nx == ST_OBJ_REQ) begin
        obj_idx_q <= obj_idx_q + 3'd1;
      end
      if (state == ST_DONE) begin
        frame_count <= frame_count + 8'd1;
        clear_q     <= 1'b0;
      end

      // A tick that cannot start a frame is dropped and counted, never queued.
      if (frame_tick && state != ST_IDLE && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

  assign draw.start_draw_bg  = start_bg_q;
  assign draw.start_draw_obj = start_obj_q;
  assign draw.clear_screen   = clear_q;
  assign draw.obj_index      = obj_idx_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed bench for frame_draw_sequencer with behavioural drawer models.
module tb_frame_draw_sequencer;
  import draw_pkg::*;

  localparam int TICK_DIV = 16;
  localparam int NUM_OBJ  = 4;

  // ---------------- clock / reset ----------------
  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       game_over = 1'b0;
  logic       frame_busy;
  logic       frame_done;
  logic [7:0] frame_count;
  logic [7:0] overrun_count;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  frame_draw_sequencer_if dif();

  frame_draw_sequencer #(
    .TICK_DIV (TICK_DIV),
    .NUM_OBJ  (NUM_OBJ)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .game_over     (game_over),
    .draw          (dif),
    .frame_busy    (frame_busy),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .state_dbg     (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drawer models (driver side) ----------------
  int bg_lat = 5, bg_hold = 1, obj_lat = 5, obj_hold = 1;

  initial begin
    int cnt;
    int rel;
    cnt = 0;
    rel = 0;
    dif.draw_bg_done = 1'b0;
    forever begin
      @(negedge clock);
      if (dif.start_draw_bg) begin
        rel = 0;
        if (!dif.draw_bg_done) begin
          cnt++;
          if (cnt >= bg_lat) dif.draw_bg_done = 1'b1;
        end
      end else begin
        cnt = 0;
        if (dif.draw_bg_done) begin
          rel++;
          if (rel >= bg_hold) begin
            dif.draw_bg_done = 1'b0;
            rel = 0;
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    int rel;
    cnt = 0;
    rel = 0;
    dif.draw_obj_done = 1'b0;
    forever begin
      @(negedge clock);
      if (dif.start_draw_obj) begin
        rel = 0;
        if (!dif.draw_obj_done) begin
          cnt++;
          if (cnt >= obj_lat) dif.draw_obj_done = 1'b1;
        end
      end else begin
        cnt = 0;
        if (dif.draw_obj_done) begin
          rel++;
          if (rel >= obj_hold) begin
            dif.draw_obj_done = 1'b0;
            rel = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  int overlap_err = 0;
  int cs_err      = 0;
  int last_gap    = 0;

  initial begin
    logic prev_bg, prev_obj, prev_busy, cs_lat, gap_on;
    int   gap;
    prev_bg = 0; prev_obj = 0; prev_busy = 0; cs_lat = 0; gap_on = 0; gap = 0;
    forever begin
      @(posedge clock);
      #2;
      if (dif.start_draw_bg && dif.start_draw_obj) overlap_err++;
      if (dif.start_draw_obj && dif.draw_bg_done) overlap_err++;
      if (dif.start_draw_obj && !prev_obj) obs_q.push_back(dif.obj_index);
      if (gap_on) begin
        gap++;
        if (dif.start_draw_obj) begin
          last_gap = gap;
          gap_on   = 0;
        end else if (frame_done) begin
          gap_on = 0;
        end
      end
      if (prev_bg && !dif.start_draw_bg) begin
        gap_on = 1;
        gap    = 0;
      end
      if (frame_busy && !prev_busy) cs_lat = dif.clear_screen;
      else if (frame_busy && dif.clear_screen !== cs_lat) cs_err++;
      prev_bg   = dif.start_draw_bg;
      prev_obj  = dif.start_draw_obj;
      prev_busy = frame_busy;
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_bg_start(input string tag, input int budget);
    int n = 0;
    while (dif.start_draw_bg !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(dif.start_draw_bg === 1'b1), 1);
  endtask

  task automatic wait_obj_start(input string tag, input int budget);
    int n = 0;
    while (dif.start_draw_obj !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(dif.start_draw_obj === 1'b1), 1);
  endtask

  task automatic wait_frame_done(input string tag, input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(frame_done === 1'b1), 1);
  endtask

  task automatic fill_exp();
    for (int i = 0; i < NUM_OBJ; i++) exp_q.push_back(3'(i));
  endtask

  task automatic check_objs(input string tag, input int base);
    chk({tag, "_nobj"}, 32'(obs_q.size() - base), NUM_OBJ);
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (exp_q.size() != 0) begin
        if (base + i < obs_q.size()) chk({tag, "_idx"}, 32'(obs_q[base+i]), 32'(exp_q[0]));
        else chk({tag, "_idx_missing"}, 0, 1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_start_bg",  32'(dif.start_draw_bg), 0);
    chk("rst_start_obj", 32'(dif.start_draw_obj), 0);
    chk("rst_clear",     32'(dif.clear_screen), 0);
    chk("rst_obj_index", 32'(dif.obj_index), 0);
    chk("rst_busy",      32'(frame_busy), 0);
    chk("rst_done",      32'(frame_done), 0);
    chk("rst_fcount",    32'(frame_count), 0);
    chk("rst_ocount",    32'(overrun_count), 0);
    chk("rst_state",     32'(state_dbg), 32'(ST_IDLE));
    resetn = 1'b1;

    // normal frame: one tick lands mid-frame
    base = obs_q.size();
    fill_exp();
    enable = 1'b1;
    wait_bg_start("n_bg_start", 40);
    enable = 1'b0;
    chk("n_clear", 32'(dif.clear_screen), 0);
    wait_frame_done("n_done", 100);
    chk("n_state_done", 32'(state_dbg), 32'(ST_DONE));
    chk("n_busy_done",  32'(frame_busy), 1);
    chk("n_fcount_pre", 32'(frame_count), 0);
    @(negedge clock);
    chk("n_pulse",   32'(frame_done), 0);
    chk("n_idle",    32'(state_dbg), 32'(ST_IDLE));
    chk("n_busy",    32'(frame_busy), 0);
    chk("n_fcount",  32'(frame_count), 1);
    chk("n_ocount",  32'(overrun_count), 1);
    chk("n_gap",     32'(last_gap), 1);
    check_objs("n", base);

    // clear frame, game_over dropped mid-frame
    base = obs_q.size();
    game_over = 1'b1;
    enable = 1'b1;
    wait_bg_start("c_bg_start", 40);
    enable = 1'b0;
    game_over = 1'b0;
    chk("c_clear_req", 32'(dif.clear_screen), 1);
    wait_frame_done("c_done", 40);
    chk("c_clear_done", 32'(dif.clear_screen), 1);
    @(negedge clock);
    chk("c_clear_idle", 32'(dif.clear_screen), 0);
    chk("c_nobj",   32'(obs_q.size() - base), 0);
    chk("c_fcount", 32'(frame_count), 2);
    chk("c_ocount", 32'(overrun_count), 1);

    // slow background release: 10-cycle done tail, two ticks dropped
    bg_hold = 10;
    base = obs_q.size();
    fill_exp();
    enable = 1'b1;
    wait_bg_start("s_bg_start", 40);
    enable = 1'b0;
    wait_frame_done("s_done", 200);
    @(negedge clock);
    bg_hold = 1;
    chk("s_gap",    32'(last_gap), 10);
    chk("s_fcount", 32'(frame_count), 3);
    chk("s_ocount", 32'(overrun_count), 3);
    check_objs("s", base);

    // overrun: 40-cycle drawers, 12 ticks dropped
    bg_lat = 40;
    obj_lat = 40;
    base = obs_q.size();
    fill_exp();
    enable = 1'b1;
    wait_bg_start("o_bg_start", 40);
    enable = 1'b0;
    wait_frame_done("o_done", 400);
    @(negedge clock);
    obj_lat = 5;
    chk("o_fcount", 32'(frame_count), 4);
    chk("o_ocount", 32'(overrun_count), 15);
    check_objs("o", base);

    // tick exactly in the DONE cycle counts as overrun
    bg_lat = 14;
    game_over = 1'b1;
    enable = 1'b1;
    wait_bg_start("d_bg_start", 40);
    enable = 1'b0;
    game_over = 1'b0;
    wait_frame_done("d_done", 40);
    @(negedge clock);
    bg_lat = 5;
    chk("d_fcount", 32'(frame_count), 5);
    chk("d_ocount", 32'(overrun_count), 16);

    // enable low across three ticks
    n = 0;
    repeat (3 * TICK_DIV + 2) begin
      @(negedge clock);
      if (state_dbg != ST_IDLE) n++;
    end
    chk("g_nonidle", 32'(n), 0);
    chk("g_fcount",  32'(frame_count), 5);
    chk("g_ocount",  32'(overrun_count), 16);

    // enable dropped during OBJ_REQ
    base = obs_q.size();
    fill_exp();
    enable = 1'b1;
    wait_obj_start("e_obj_start", 80);
    enable = 1'b0;
    wait_frame_done("e_done", 100);
    @(negedge clock);
    chk("e_fcount", 32'(frame_count), 6);
    chk("e_ocount", 32'(overrun_count), 17);
    check_objs("e", base);

    // long background draw drives overrun_count into saturation
    bg_lat = 5000;
    enable = 1'b1;
    wait_bg_start("sat_bg_start", 40);
    enable = 1'b0;
    wait_frame_done("sat_done", 6000);
    @(negedge clock);
    bg_lat = 5;
    chk("sat_fcount", 32'(frame_count), 7);
    chk("sat_ocount", 32'(overrun_count), 255);

    // asynchronous reset in the middle of an object request
    enable = 1'b1;
    wait_obj_start("r_obj_start", 80);
    #2;
    resetn = 1'b0;
    #1;
    chk("r_start_obj", 32'(dif.start_draw_obj), 0);
    chk("r_start_bg",  32'(dif.start_draw_bg), 0);
    chk("r_fcount",    32'(frame_count), 0);
    chk("r_ocount",    32'(overrun_count), 0);
    chk("r_obj_index", 32'(dif.obj_index), 0);
    chk("r_busy",      32'(frame_busy), 0);
    chk("r_state",     32'(state_dbg), 32'(ST_IDLE));
    @(negedge clock);
    resetn = 1'b1;
    n = 0;
    while (dif.start_draw_bg !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("r_first_tick", 32'(n), 16);
    enable = 1'b0;
    wait_frame_done("r_done", 100);
    @(negedge clock);
    chk("r_fcount_after", 32'(frame_count), 1);

    chk("overlap_err", 32'(overlap_err), 0);
    chk("clear_stable_err", 32'(cs_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
